// File: rtl/up_sampler_pkg.sv
// Shared definitions for the up-sampler and its sibling decimator.
// Optional build macro: UP_SAMPLER_HOLD_EN (sample-and-hold mode).
package up_sampler_pkg;

  // Default sample width, shared with the decimator.
  localparam int SAMPLE_W = 10;

  // Output phase of the 1:2 interpolator.
  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } phase_t;

endpackage

// File: rtl/up_sampler_midpoint_avg.sv
// midpoint_avg: combinational floor((a+b)/2) of two signed samples.
// The sum is formed at Width+1 bits, so the halved result always fits in Width.
module midpoint_avg
  import up_sampler_pkg::*;
#(
  parameter int Width = SAMPLE_W
) (
  input  logic signed [Width-1:0] a,
  input  logic signed [Width-1:0] b,
  output logic signed [Width-1:0] y
);

  logic signed [Width:0] sum;

  // Widen, add, then arithmetic shift right for floor rounding.
  always_comb begin
    sum = {a[Width-1], a} + {b[Width-1], b};
    y   = Width'(sum >>> 1);
  end

endmodule

// File: rtl/up_sampler.sv
// up_sampler: 1:2 interpolating up-sampler.
// Each accepted sample yields two outputs on consecutive enabled edges:
// the midpoint with the previous sample, then the sample itself.
// Build macro UP_SAMPLER_HOLD_EN selects sample-and-hold mode (first output
// is the sample itself; the prev/primed logic is not built).
//
// state  | meaning
// IDLE   | ready for a new sample; emits the first output of a pair on accept
// SECOND | first output issued; emits the held sample (cur) on next enabled edge
module up_sampler
  import up_sampler_pkg::*;
#(
  parameter int Width = SAMPLE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [Width-1:0] data_in,
  input  logic                    valid_in,
  output logic                    ready_in,
  output logic signed [Width-1:0] data_out,
  output logic                    valid_out,
  output logic                    overrun
);

  phase_t                  phase;
  phase_t                  phase_nxt;
  logic                    accept;
  logic                    drop;
  logic signed [Width-1:0] cur;

`ifndef UP_SAMPLER_HOLD_EN
  logic signed [Width-1:0] prev;
  logic                    primed;
  logic signed [Width-1:0] mid;

  midpoint_avg #(.Width(Width)) u_mid (
    .a (prev),
    .b (data_in),
    .y (mid)
  );
`endif

  // Handshake decode and next phase.
  always_comb begin
    phase_nxt = phase;
    ready_in  = en && (phase == IDLE);
    accept    = ready_in && valid_in;
    drop      = en && valid_in && !ready_in;
    if (en) begin
      case (phase)
        IDLE:    if (valid_in) phase_nxt = SECOND;
        SECOND:  phase_nxt = IDLE;
        default: phase_nxt = IDLE;
      endcase
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) phase <= IDLE;
    else     phase <= phase_nxt;
  end

  // Output datapath, sample history and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      overrun   <= 1'b0;
      cur       <= '0;
`ifndef UP_SAMPLER_HOLD_EN
      prev      <= '0;
      primed    <= 1'b0;
`endif
    end else begin
      if (drop) overrun <= 1'b1;
      if (!en) begin
        valid_out <= 1'b0;
      end else if (accept) begin
        cur       <= data_in;
        valid_out <= 1'b1;
`ifdef UP_SAMPLER_HOLD_EN
        data_out  <= data_in;
`else
        prev      <= data_in;
        primed    <= 1'b1;
        data_out  <= primed ? mid : data_in;
`endif
      end else if (phase == SECOND) begin
        data_out  <= cur;
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_up_sampler.sv
// Self-checking bench for up_sampler (either build of UP_SAMPLER_HOLD_EN).
module tb_up_sampler;
  import up_sampler_pkg::*;

  localparam int W = SAMPLE_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic signed [W-1:0] data_in;
  logic                valid_in;
  logic                ready_in;
  logic signed [W-1:0] data_out;
  logic                valid_out;
  logic                overrun;

  up_sampler #(.Width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state and scoreboard.
  int     q[$];
  int     obs[$];
  int     m_prev;
  bit     m_primed;
  bit     m_second;
  bit     m_ovr;
  int     m_last;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_half(input int a, input int b);
    int s;
    s = a + b;
    if (s < 0 && (s % 2) != 0) return s / 2 - 1;
    return s / 2;
  endfunction

  // One clock of stimulus; called just after a falling edge.
  task automatic step(input bit e, input bit v, input int d);
    bit emit;
    int exp;
    rst      = 1'b0;
    en       = e;
    valid_in = v;
    data_in  = d[W-1:0];
    #1;
    chk("ready_in", int'(ready_in), int'(e && !m_second));
    emit = 1'b0;
    if (e) begin
      if (v && !m_second) begin
`ifdef UP_SAMPLER_HOLD_EN
        q.push_back(d);
`else
        q.push_back(m_primed ? floor_half(m_prev, d) : d);
`endif
        q.push_back(d);
        m_prev   = d;
        m_primed = 1'b1;
        m_second = 1'b1;
        emit     = 1'b1;
      end else if (m_second) begin
        if (v) m_ovr = 1'b1;
        m_second = 1'b0;
        emit     = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("valid_out", int'(valid_out), int'(emit));
    if (emit) begin
      exp    = (q.size() > 0) ? q.pop_front() : 32'h7fff_ffff;
      chk("data_out", int'(data_out), exp);
      m_last = exp;
      obs.push_back(int'(data_out));
    end else begin
      chk("data_hold", int'(data_out), m_last);
    end
    chk("overrun", int'(overrun), int'(m_ovr));
  endtask

  // Reset edge, with en/valid_in asserted to show reset wins.
  task automatic do_reset();
    rst      = 1'b1;
    en       = 1'b1;
    valid_in = 1'b1;
    data_in  = W'(55);
    @(posedge clk);
    @(negedge clk);
    q.delete();
    m_prev = 0; m_primed = 0; m_second = 0; m_ovr = 0; m_last = 0;
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst      = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("rst_ready_in", int'(ready_in), 1);
    @(negedge clk);
  endtask

  task automatic chk_obs(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_count"}, obs.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_%0d", tag, i), (i < obs.size()) ? obs[i] : 32'h7fff_ffff, e[i]);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid_in = 1'b0; data_in = '0;
    @(negedge clk);
    do_reset();

    // Reset right after an accept discards the pending second sample.
    step(1, 1, 100);
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);

    // Priming then interpolation.
    obs.delete();
    step(1, 1, 100); step(1, 0, 0); step(1, 1, 200); step(1, 0, 0);
`ifdef UP_SAMPLER_HOLD_EN
    chk_obs("prime", 100, 100, 200, 200);
`else
    chk_obs("prime", 100, 100, 150, 200);
`endif

    // Negative floor and most-negative boundary.
    step(1, 1, 511); step(1, 0, 0);
    obs.delete();
    step(1, 1, -512); step(1, 0, 0); step(1, 1, -512); step(1, 0, 0);
`ifdef UP_SAMPLER_HOLD_EN
    chk_obs("floor", -512, -512, -512, -512);
`else
    chk_obs("floor", -1, -512, -512, -512);
`endif

    // Enable stall while in SECOND; valid_in during stall is ignored.
    step(1, 1, 77);
    step(0, 1, 5); step(0, 0, 0); step(0, 1, 6);
    step(1, 0, 0);
    chk("stall_no_overrun", int'(overrun), 0);

    // Overrun with valid_in held every cycle.
    do_reset();
    obs.delete();
    step(1, 1, 10); step(1, 1, 20); step(1, 1, 30); step(1, 1, 40);
`ifdef UP_SAMPLER_HOLD_EN
    chk_obs("ovr", 10, 10, 30, 30);
`else
    chk_obs("ovr", 10, 10, 20, 30);
`endif
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("ovr_sticky", int'(overrun), 1);
    do_reset();

    // Random traffic with stalls and occasional back-to-back valids.
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 5) != 0, $urandom_range(0, 2) != 0,
           int'($urandom_range(0, 1023)) - 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
